// File: rtl/pci_arb_pkg.sv
// Shared types and helpers for the PCI bus arbiter.
package pci_arb_pkg;

  localparam int ARB_TIMEOUT_DEF = 16;
  localparam int MAX_MASTERS     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_BUSY  = 3'd2,
    ST_GAP   = 3'd3,
    ST_PARK  = 3'd4
  } arb_state_t;

  // Bus is idle when neither FRAME_ nor IRDY_ is asserted.
  function automatic logic bus_idle(input logic frame_n, input logic irdy_n);
    return frame_n & irdy_n;
  endfunction

endpackage

// File: rtl/pci_bus_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first requester after last_winner, wrapping.
module rr_priority_pick
  import pci_arb_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int W         = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [W-1:0]         last_winner,
  output logic [W-1:0]         winner,
  output logic                 any_req
);

  int                   idx;
  logic                 found;
  logic [N_MASTERS-1:0] sh;

  always_comb begin
    winner  = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    sh      = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = int'(last_winner) + i;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      sh = req >> idx;
      if (!found && sh[0]) begin
        found  = 1'b1;
        winner = W'(idx);
      end
    end
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central round-robin PCI bus arbiter with one-cycle turnaround gap and grant timeout.
// Optional bus parking is enabled by defining PCI_ARB_PARK_EN.
module pci_bus_arbiter
  import pci_arb_pkg::*;
#(
  parameter int N_MASTERS   = 4,
  parameter int ARB_TIMEOUT = ARB_TIMEOUT_DEF,
  parameter int PARK_MASTER = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_MASTERS-1:0]         req_,
  input  logic                         FRAME_,
  input  logic                         IRDY_,
  output logic [N_MASTERS-1:0]         gnt_,
  output logic [$clog2(N_MASTERS)-1:0] owner,
  output logic                         owner_vld,
  output logic                         timeout_evt
);

  // state | meaning
  // IDLE  | no grant, waiting for a request
  // GRANT | gnt_[w] low, waiting for w to start; timeout counter runs on idle bus
  // BUSY  | w owns the bus; released on its req_ high or another request
  // GAP   | all grants high for one cycle between owners
  // PARK  | no request pending, PARK_MASTER holds the grant (parking builds only)

  localparam int W  = $clog2(N_MASTERS);
  localparam int CW = $clog2(ARB_TIMEOUT) + 1;
  localparam logic [W-1:0] PARK_IDX = W'(PARK_MASTER);

`ifdef PCI_ARB_PARK_EN
  localparam arb_state_t ST_REST = ST_PARK;
`else
  localparam arb_state_t ST_REST = ST_IDLE;
`endif

  if (N_MASTERS < 2 || N_MASTERS > MAX_MASTERS) begin : g_bad_n
    $error("pci_bus_arbiter: N_MASTERS out of range");
  end

  arb_state_t           state_q, state_d;
  logic [W-1:0]         win_q, win_d;
  logic [W-1:0]         last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 idle_q;
  logic                 to_d;
  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] win_oh;
  logic [N_MASTERS-1:0] others;
  logic [W-1:0]         pick;
  logic                 any_req;
  logic                 idle_now;
  logic                 start;

  assign req      = ~req_;
  assign idle_now = bus_idle(FRAME_, IRDY_);
  // A start is FRAME_ asserting on a bus that was idle the previous cycle.
  assign start    = idle_q & ~FRAME_;

  rr_priority_pick #(.N_MASTERS(N_MASTERS), .W(W)) u_pick (
    .req         (req),
    .last_winner (last_q),
    .winner      (pick),
    .any_req     (any_req)
  );

  always_comb begin
    win_oh         = '0;
    win_oh[win_q]  = 1'b1;
    others         = req & ~win_oh;
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANT;
          win_d   = pick;
          last_d  = pick;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (start) begin
          state_d = ST_BUSY;
        end else if (req_[win_q]) begin
          state_d = ST_GAP;
        end else if (idle_now) begin
          if (cnt_q == CW'(ARB_TIMEOUT - 1)) begin
            state_d = ST_GAP;
            to_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (req_[win_q] || (|others)) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (any_req) begin
          state_d = ST_GRANT;
          win_d   = pick;
          last_d  = pick;
          cnt_d   = '0;
        end else begin
          state_d = ST_REST;
          win_d   = PARK_IDX;
        end
      end
      ST_PARK: begin
`ifdef PCI_ARB_PARK_EN
        if (start) begin
          state_d = ST_BUSY;
        end else if (|others) begin
          state_d = ST_GAP;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_REST;
    endcase
  end

  // Outputs follow the state one clock later, so GAP shows as one all-high gnt_ cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_REST;
      win_q       <= PARK_IDX;
      last_q      <= W'(N_MASTERS - 1);
      cnt_q       <= '0;
      idle_q      <= 1'b1;
      gnt_        <= '1;
      owner       <= '0;
      owner_vld   <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_now;
      timeout_evt <= to_d;
      if (state_q == ST_GRANT || state_q == ST_BUSY || state_q == ST_PARK) begin
        gnt_      <= ~win_oh;
        owner     <= win_q;
        owner_vld <= 1'b1;
      end else begin
        gnt_      <= '1;
        owner_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed self-checking bench for pci_bus_arbiter (N_MASTERS=4, ARB_TIMEOUT=16).
module tb_pci_bus_arbiter;
  import pci_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_;
  logic       FRAME_;
  logic       IRDY_;
  logic [3:0] gnt_;
  logic [1:0] owner;
  logic       owner_vld;
  logic       timeout_evt;

  int n_tests = 0;
  int n_fail  = 0;

  pci_bus_arbiter #(.N_MASTERS(4), .ARB_TIMEOUT(16), .PARK_MASTER(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_        (req_),
    .FRAME_      (FRAME_),
    .IRDY_       (IRDY_),
    .gnt_        (gnt_),
    .owner       (owner),
    .owner_vld   (owner_vld),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req_   = 4'b1111;
    FRAME_ = 1'b1;
    IRDY_  = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    req_   = 4'b1111;
    FRAME_ = 1'b1;
    IRDY_  = 1'b1;
    step();
    step();
    n_tests++; if (gnt_ !== 4'b1111) begin n_fail++; $display("FAIL reset_gnt: got %b want 1111", gnt_); end
    n_tests++; if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner); end
    n_tests++; if (owner_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", owner_vld); end
    n_tests++; if (timeout_evt !== 1'b0) begin n_fail++; $display("FAIL reset_to: got %b want 0", timeout_evt); end
`ifndef PCI_ARB_PARK_EN
    n_tests++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
`endif
    n_tests++; if (dut.last_q !== 2'd3) begin n_fail++; $display("FAIL reset_last: got %0d want 3", dut.last_q); end
    reset = 1'b0;
  endtask

`ifndef PCI_ARB_PARK_EN
  task automatic test_first_grant();
    do_reset();
    req_ = 4'b1110;
    step();
    n_tests++; if (gnt_ !== 4'b1111) begin n_fail++; $display("FAIL first_lat: got %b want 1111", gnt_); end
    step();
    n_tests++; if (gnt_ !== 4'b1110) begin n_fail++; $display("FAIL first_gnt: got %b want 1110", gnt_); end
    n_tests++; if (owner !== 2'd0 || owner_vld !== 1'b1) begin n_fail++; $display("FAIL first_owner: got %0d/%b want 0/1", owner, owner_vld); end
    FRAME_ = 1'b0;
    step();
    n_tests++; if (dut.state_q !== ST_BUSY) begin n_fail++; $display("FAIL first_busy: got %0d want BUSY", dut.state_q); end
    req_   = 4'b1111;
    FRAME_ = 1'b1;
    step();
    step();
    n_tests++; if (gnt_ !== 4'b1111 || owner_vld !== 1'b0) begin n_fail++; $display("FAIL first_release: got %b/%b want 1111/0", gnt_, owner_vld); end
  endtask

  task automatic test_rotate();
    logic [3:0] exp;
    do_reset();
    req_ = 4'b0000;
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c >= 2 && ((c - 2) % 4) != 3) exp = ~(4'b0001 << ((c - 2) / 4 % 4));
      else exp = 4'b1111;
      n_tests++; if (gnt_ !== exp) begin n_fail++; $display("FAIL rotate_c%0d: got %b want %b", c, gnt_, exp); end
      // Bench acts as the granted master: one address phase, one data phase.
      if (!FRAME_) begin FRAME_ = 1'b1; IRDY_ = 1'b0; end
      else if (!IRDY_) IRDY_ = 1'b1;
      else if (gnt_ != 4'b1111) FRAME_ = 1'b0;
    end
    req_   = 4'b1111;
    FRAME_ = 1'b1;
    IRDY_  = 1'b1;
    step();
    step();
  endtask

  task automatic test_timeout();
    logic [3:0] exp;
    int pulses;
    pulses = 0;
    do_reset();
    req_ = 4'b1011;
    for (int c = 1; c <= 19; c++) begin
      step();
      exp = ((c >= 2 && c <= 17) || c == 19) ? 4'b1011 : 4'b1111;
      n_tests++; if (gnt_ !== exp) begin n_fail++; $display("FAIL timeout_gnt_c%0d: got %b want %b", c, gnt_, exp); end
      n_tests++; if (timeout_evt !== (c == 17)) begin n_fail++; $display("FAIL timeout_evt_c%0d: got %b want %b", c, timeout_evt, (c == 17)); end
      if (timeout_evt === 1'b1) pulses++;
    end
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL timeout_pulses: got %0d want 1", pulses); end
    req_ = 4'b1111;
    step();
    step();
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_ = 4'b0110;
    step();
    step();
    n_tests++; if (gnt_ !== 4'b1110) begin n_fail++; $display("FAIL simul_first: got %b want 1110", gnt_); end
    req_ = 4'b0111;
    step();
    n_tests++; if (gnt_ !== 4'b1110) begin n_fail++; $display("FAIL simul_hold: got %b want 1110", gnt_); end
    step();
    n_tests++; if (gnt_ !== 4'b1111) begin n_fail++; $display("FAIL simul_gap: got %b want 1111", gnt_); end
    step();
    n_tests++; if (gnt_ !== 4'b0111 || owner !== 2'd3) begin n_fail++; $display("FAIL simul_next: got %b/%0d want 0111/3", gnt_, owner); end
  endtask

  task automatic test_preempt();
    do_reset();
    req_ = 4'b1101;
    step();
    step();
    n_tests++; if (gnt_ !== 4'b1101) begin n_fail++; $display("FAIL preempt_gnt1: got %b want 1101", gnt_); end
    FRAME_ = 1'b0;
    IRDY_  = 1'b0;
    step();
    n_tests++; if (dut.state_q !== ST_BUSY) begin n_fail++; $display("FAIL preempt_busy: got %0d want BUSY", dut.state_q); end
    req_ = 4'b0101;
    step();
    n_tests++; if (gnt_ !== 4'b1101) begin n_fail++; $display("FAIL preempt_e4: got %b want 1101", gnt_); end
    step();
    n_tests++; if (gnt_ !== 4'b1111) begin n_fail++; $display("FAIL preempt_gap: got %b want 1111", gnt_); end
    step();
    n_tests++; if (gnt_ !== 4'b0111 || owner !== 2'd3) begin n_fail++; $display("FAIL preempt_gnt3: got %b/%0d want 0111/3", gnt_, owner); end
    for (int c = 0; c < 4; c++) step();
    n_tests++; if (dut.cnt_q !== 0 || gnt_ !== 4'b0111) begin n_fail++; $display("FAIL preempt_hold: got cnt %0d gnt %b want 0/0111", dut.cnt_q, gnt_); end
    FRAME_ = 1'b1;
    IRDY_  = 1'b1;
    step();
    n_tests++; if (dut.cnt_q !== 1) begin n_fail++; $display("FAIL preempt_cnt: got %0d want 1", dut.cnt_q); end
    FRAME_ = 1'b0;
    step();
    n_tests++; if (dut.state_q !== ST_BUSY || gnt_ !== 4'b0111) begin n_fail++; $display("FAIL preempt_busy3: got %0d/%b want BUSY/0111", dut.state_q, gnt_); end
  endtask

  task automatic test_reset_busy();
    reset = 1'b1;
    step();
    n_tests++; if (gnt_ !== 4'b1111 || owner_vld !== 1'b0) begin n_fail++; $display("FAIL rbusy_gnt: got %b/%b want 1111/0", gnt_, owner_vld); end
    n_tests++; if (owner !== 2'd0 || dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL rbusy_state: got %0d/%0d want 0/IDLE", owner, dut.state_q); end
    reset  = 1'b0;
    FRAME_ = 1'b1;
    IRDY_  = 1'b1;
    req_   = 4'b0000;
    step();
    step();
    n_tests++; if (gnt_ !== 4'b1110 || owner !== 2'd0) begin n_fail++; $display("FAIL rbusy_first: got %b/%0d want 1110/0", gnt_, owner); end
    req_ = 4'b1111;
    step();
    step();
  endtask

  task automatic test_idle_float();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step();
      n_tests++; if (gnt_ !== 4'b1111 || owner_vld !== 1'b0 || timeout_evt !== 1'b0) begin
        n_fail++; $display("FAIL float_c%0d: got %b/%b/%b want 1111/0/0", c, gnt_, owner_vld, timeout_evt);
      end
    end
  endtask
`else
  task automatic test_park();
    do_reset();
    for (int c = 0; c < 25; c++) begin
      step();
      n_tests++; if (gnt_ !== 4'b1110 || owner_vld !== 1'b1 || timeout_evt !== 1'b0) begin
        n_fail++; $display("FAIL park_c%0d: got %b/%b/%b want 1110/1/0", c, gnt_, owner_vld, timeout_evt);
      end
    end
    req_ = 4'b1011;
    step();
    n_tests++; if (gnt_ !== 4'b1110) begin n_fail++; $display("FAIL park_leave: got %b want 1110", gnt_); end
    step();
    n_tests++; if (gnt_ !== 4'b1111) begin n_fail++; $display("FAIL park_gap: got %b want 1111", gnt_); end
    step();
    n_tests++; if (gnt_ !== 4'b1011 || owner !== 2'd2) begin n_fail++; $display("FAIL park_gnt2: got %b/%0d want 1011/2", gnt_, owner); end
  endtask
`endif

  initial begin
    reset  = 1'b1;
    req_   = 4'b1111;
    FRAME_ = 1'b1;
    IRDY_  = 1'b1;
    test_reset();
`ifndef PCI_ARB_PARK_EN
    test_first_grant();
    test_rotate();
    test_timeout();
    test_simultaneous();
    test_preempt();
    test_reset_busy();
    test_idle_float();
`else
    test_park();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pci_bus_arbiter.md
# pci_bus_arbiter

Central PCI bus arbiter sharing one PCI bus among up to `N_MASTERS` initiators. It samples each master's active-low request, drives exactly one active-low grant under round-robin priority, and monitors `FRAME_`/`IRDY_` to detect bus ownership and idle. It enforces a one-cycle all-grants-deasserted gap between owners and revokes grants that are never used. It sits beside the bus protocol checker on the same PCI signal set.

## Interface
- `N_MASTERS`, default 4: number of requesters, 2..8.
- `ARB_TIMEOUT`, default 16: idle-bus clocks a granted master has to assert `FRAME_` before the grant is revoked.
- `PARK_MASTER`, default 0: master index parked on when no request is pending (used only with parking enabled).
- `clk` input 1: bus clock; all logic on posedge.
- `reset` input 1: synchronous, active-high reset.
- `req_` input N_MASTERS: per-master request, active low.
- `FRAME_` input 1: PCI FRAME_, active low.
- `IRDY_` input 1: PCI IRDY_, active low.
- `gnt_` output N_MASTERS: per-master grant, active low, registered.
- `owner` output $clog2(N_MASTERS): index of the currently granted master.
- `owner_vld` output 1: high when a grant is asserted.
- `timeout_evt` output 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- Bus idle is `FRAME_ & IRDY_` sampled high. A transaction starts when `FRAME_` is sampled low while idle.
- Round-robin: search starts at `last_winner+1` modulo N_MASTERS. `last_winner` updates when a grant is issued and resets to N_MASTERS-1, so master 0 has first priority after reset.
- States:
  - IDLE: all `gnt_` high. If any `req_` is low, latch the winner and go to GRANT.
  - GRANT: `gnt_[w]` low, timeout counter running.
    - `FRAME_` falls while bus idle -> BUSY.
    - `req_[w]` high before start -> GAP.
    - Counter reaches ARB_TIMEOUT-1 -> GAP and pulse `timeout_evt`.
  - BUSY: `gnt_[w]` stays low while no other request is pending. When another master requests, deassert `gnt_[w]` (the current transaction completes on its own) and go to GAP. When `req_[w]` goes high, go to GAP.
  - GAP: all `gnt_` high for exactly one cycle. Next state is GRANT for the next winner, or IDLE (PARK when enabled) if nothing is requested.
  - PARK (macro only): described under Configuration.
- The timeout counter clears on entry to GRANT. It increments only while the bus is idle, so it holds while a previous owner finishes.
- Invariant: at most one `gnt_` bit is low in any cycle.
- A grant never moves directly from one master to another; GAP always separates them.

## Timing
- Reset values: `gnt_` all ones, `owner`=0, `owner_vld`=0, `timeout_evt`=0, state IDLE, counter 0, `last_winner`=N_MASTERS-1.
- Request-to-grant latency from IDLE is 1 clock: `req_` is sampled at edge k and `gnt_` is low after edge k+1.
- Re-grant latency after a revoke is 2 clocks: one clock in GAP, then the new grant.
- Simultaneous requests are resolved purely by round-robin order within a single cycle.
- A request withdrawn in the same cycle it would win is ignored; the search uses that cycle's sampled `req_`.
- `reset` asserted mid-transaction forces the reset values at the next edge, regardless of `FRAME_`.
- `timeout_evt` is high in the first GAP cycle only.

## Configuration
- `PCI_ARB_PARK_EN` defined:
  - IDLE is replaced by PARK, which drives `gnt_[PARK_MASTER]` low with `owner_vld`=1 and no timeout.
  - A parked master that starts a transaction -> BUSY.
  - Any request from another master -> GAP -> GRANT.
  - Reset still forces all grants high; PARK is entered on the first cycle after reset deasserts.
- `PCI_ARB_PARK_EN` undefined: the bus floats ungranted when no request is pending, and `PARK_MASTER` is unused.

## Structure
- Package `pci_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, GRANT, BUSY, GAP, PARK);
  - the bus-idle helper function;
  - the default constants for timeout and maximum master count.
- Sub-module `rr_priority_pick`: combinational round-robin picker. Inputs are the request vector and `last_winner`; outputs are the winner index and an any-request flag. The FSM, counter and grant registers live in the top.

## Test plan
- Reset, then `req_`=4'b1110 -> `gnt_`=4'b1110 one clock later and `owner`=0. `FRAME_` falls -> state BUSY.
- `req_`=4'b0000 held, each master running one transaction -> grants rotate 0,1,2,3,0, each separated by exactly one all-ones `gnt_` cycle.
- Master 2 granted and never asserts `FRAME_` with the bus idle -> `gnt_[2]` deasserts after 16 clocks and `timeout_evt` pulses once.
- Master 1 in BUSY, master 3 requests -> `gnt_[1]` deasserts next clock, GAP, then `gnt_[3]` low while `FRAME_` is still low. The counter holds until the bus is idle.
- `reset` pulsed during BUSY -> next clock `gnt_`=4'b1111, `owner_vld`=0, and master 0 wins first after release.
- With `PCI_ARB_PARK_EN` and no requests -> `gnt_`=4'b1110 with no timeout. Master 2 requests -> GAP, then `gnt_`=4'b1011.
